// File: rtl/mem_wb_slice.sv
// ---------------------------------------------------------------------------
// mem_wb_slice -- back half of the 5-stage pipeline (MEM and WB stages).
//
// Takes the M/WB control bundles and EX results, performs the data-memory
// access through a req/ready handshake, and drives the register-file write
// port and the RET redirect back toward decode.
//
// Optional feature: define MEM_TIMEOUT_EN to abort a memory access after
// TIMEOUT cycles without mem_ready. The abort sets the sticky mem_err flag.
// Without the macro the block waits indefinitely and mem_err is tied to 0.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   ex_valid          EX presents a valid instruction
//   alu_result        memory address or register result
//   store_data        data to store
//   pc_inc            PC+1, stored instead of store_data when pc_to_mem=1
//   pc_to_mem         select pc_inc as store data (CALL)
//   M                 {MemWrite, MemRead}
//   WB                {dst_addr[3:0], RegWrite, Ret, MemToReg}
//   mem_req/we/addr/wdata   memory request, all registered
//   mem_rdata/mem_ready     memory response
//   stall             upstream must freeze and hold its inputs
//   write_addr/write_data/reg_write   register-file write port
//   ret_valid/ret_target             one-cycle RET redirect
//   mem_err           sticky timeout flag
// ---------------------------------------------------------------------------
module mem_wb_slice #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  input  logic [15:0] alu_result,
  input  logic [15:0] store_data,
  input  logic [15:0] pc_inc,
  input  logic        pc_to_mem,
  input  logic [1:0]  M,
  input  logic [6:0]  WB,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ready,
  output logic        stall,
  output logic [3:0]  write_addr,
  output logic [15:0] write_data,
  output logic        reg_write,
  output logic        ret_valid,
  output logic [15:0] ret_target,
  output logic        mem_err
);

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  state_t state_q;

  // MEM register: the op currently in the memory stage.
  logic        mv_q;
  logic        m_write_q;
  logic        m_regwrite_q;
  logic        m_ret_q;
  logic        m_memtoreg_q;
  logic [3:0]  m_dst_q;
  logic [15:0] m_alu_q;

  // Memory interface registers, stable for the whole access.
  logic        mem_req_q;
  logic        mem_we_q;
  logic [15:0] mem_addr_q;
  logic [15:0] mem_wdata_q;

  // WB register.
  logic        reg_write_q;
  logic [3:0]  write_addr_q;
  logic [15:0] write_data_q;
  logic        ret_valid_q;
  logic [15:0] ret_target_q;

  // Next-state values.
  logic        stall_d;
  logic        mem_done_d;
  logic        wb_fire_d;
  logic        ex_mem_op_d;
  logic [15:0] wdata_sel_d;
  logic [15:0] rdata_eff_d;
  logic        reg_write_d;
  logic [3:0]  write_addr_d;
  logic [15:0] write_data_d;
  logic        ret_valid_d;
  logic [15:0] ret_target_d;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q;
  logic             mem_err_q;
  logic             timeout_hit_d;

  // cnt_q counts completed ACCESS cycles minus one, so the abort fires on
  // the edge that ends the TIMEOUT-th waiting cycle.
  assign timeout_hit_d = (state_q == ACCESS) && !mem_ready &&
                         (cnt_q == CNT_W'(TIMEOUT - 1));
  assign mem_err = mem_err_q;
`else
  logic [31:0] timeout_unused;
  assign timeout_unused = 32'(TIMEOUT);
  assign mem_err = 1'b0;
`endif

  always_comb begin
    stall_d     = (state_q == ACCESS) && !mem_ready;
    mem_done_d  = (state_q == ACCESS) && mem_ready;
    ex_mem_op_d = ex_valid && (M[1] || M[0]);
    wdata_sel_d = pc_to_mem ? pc_inc : store_data;

    // In IDLE the MEM register can only hold a non-memory op or a bubble,
    // so it retires on every edge; a memory op retires only on mem_ready.
    wb_fire_d = mem_done_d || ((state_q == IDLE) && mv_q);

    // A write (including MemRead+MemWrite) never returns register data.
    rdata_eff_d = (mem_done_d && !m_write_q) ? mem_rdata : 16'h0000;

    reg_write_d  = wb_fire_d && m_regwrite_q;
    write_addr_d = wb_fire_d ? m_dst_q : 4'h0;
    write_data_d = 16'h0000;
    if (reg_write_d) begin
      write_data_d = (m_memtoreg_q && !m_write_q) ? rdata_eff_d : m_alu_q;
    end
    ret_valid_d  = wb_fire_d && m_ret_q;
    ret_target_d = ret_valid_d ? rdata_eff_d : 16'h0000;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      mv_q         <= 1'b0;
      m_write_q    <= 1'b0;
      m_regwrite_q <= 1'b0;
      m_ret_q      <= 1'b0;
      m_memtoreg_q <= 1'b0;
      m_dst_q      <= 4'h0;
      m_alu_q      <= 16'h0000;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= 16'h0000;
      mem_wdata_q  <= 16'h0000;
      reg_write_q  <= 1'b0;
      write_addr_q <= 4'h0;
      write_data_q <= 16'h0000;
      ret_valid_q  <= 1'b0;
      ret_target_q <= 16'h0000;
`ifdef MEM_TIMEOUT_EN
      cnt_q        <= '0;
      mem_err_q    <= 1'b0;
`endif
    end else begin
      // The WB register reloads every edge; when nothing retires it takes
      // a bubble, which turns ret_valid into a single-cycle pulse.
      reg_write_q  <= reg_write_d;
      write_addr_q <= write_addr_d;
      write_data_q <= write_data_d;
      ret_valid_q  <= ret_valid_d;
      ret_target_q <= ret_target_d;

      if (!stall_d) begin
        // Accept the next EX op; a memory op enters ACCESS on this edge.
        state_q      <= ex_mem_op_d ? ACCESS : IDLE;
        mv_q         <= ex_valid;
        m_write_q    <= ex_valid && M[1];
        m_regwrite_q <= ex_valid && WB[2];
        m_ret_q      <= ex_valid && WB[1];
        m_memtoreg_q <= ex_valid && WB[0];
        m_dst_q      <= ex_valid ? WB[6:3] : 4'h0;
        m_alu_q      <= ex_valid ? alu_result : 16'h0000;
        mem_req_q    <= ex_mem_op_d;
        mem_we_q     <= ex_mem_op_d && M[1];
        mem_addr_q   <= ex_mem_op_d ? alu_result : 16'h0000;
        mem_wdata_q  <= ex_mem_op_d ? wdata_sel_d : 16'h0000;
`ifdef MEM_TIMEOUT_EN
        cnt_q        <= '0;
`endif
      end
`ifdef MEM_TIMEOUT_EN
      else if (timeout_hit_d) begin
        // Abort: drop the op so IDLE does not retire it, and flag the error.
        state_q      <= IDLE;
        mv_q         <= 1'b0;
        m_write_q    <= 1'b0;
        m_regwrite_q <= 1'b0;
        m_ret_q      <= 1'b0;
        m_memtoreg_q <= 1'b0;
        m_dst_q      <= 4'h0;
        m_alu_q      <= 16'h0000;
        mem_req_q    <= 1'b0;
        mem_we_q     <= 1'b0;
        mem_addr_q   <= 16'h0000;
        mem_wdata_q  <= 16'h0000;
        cnt_q        <= '0;
        mem_err_q    <= 1'b1;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
`endif
    end
  end

  assign stall      = stall_d;
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign reg_write  = reg_write_q;
  assign write_addr = write_addr_q;
  assign write_data = write_data_q;
  assign ret_valid  = ret_valid_q;
  assign ret_target = ret_target_q;

endmodule

// File: tb/tb_mem_wb_slice.sv
// ---------------------------------------------------------------------------
// tb_mem_wb_slice -- directed, table-driven bench for mem_wb_slice.
// Each table row holds the inputs for one clock cycle and the outputs
// expected during that cycle (sampled 1 time unit after the rising edge).
// ---------------------------------------------------------------------------
module tb_mem_wb_slice;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ex_valid;
  logic [15:0] alu_result;
  logic [15:0] store_data;
  logic [15:0] pc_inc;
  logic        pc_to_mem;
  logic [1:0]  M;
  logic [6:0]  WB;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ready;
  logic        stall;
  logic [3:0]  write_addr;
  logic [15:0] write_data;
  logic        reg_write;
  logic        ret_valid;
  logic [15:0] ret_target;
  logic        mem_err;

  int n_run = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_wb_slice #(.TIMEOUT(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ex_valid   (ex_valid),
    .alu_result (alu_result),
    .store_data (store_data),
    .pc_inc     (pc_inc),
    .pc_to_mem  (pc_to_mem),
    .M          (M),
    .WB         (WB),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready),
    .stall      (stall),
    .write_addr (write_addr),
    .write_data (write_data),
    .reg_write  (reg_write),
    .ret_valid  (ret_valid),
    .ret_target (ret_target),
    .mem_err    (mem_err)
  );

  typedef struct packed {
    logic        ev;
    logic [1:0]  m;
    logic [6:0]  wb;
    logic [15:0] alu;
    logic [15:0] sd;
    logic [15:0] pci;
    logic        ptm;
    logic        rdy;
    logic [15:0] rdata;
    logic [4:0]  e_flags;  // {mem_req, mem_we, stall, reg_write, ret_valid}
    logic [15:0] e_maddr;
    logic [15:0] e_mwdata;
    logic [3:0]  e_waddr;
    logic [15:0] e_wdata;
    logic [15:0] e_rt;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs [NV];

  function automatic vec_t mk(
    input logic ev, input logic [1:0] m, input logic [6:0] wb,
    input logic [15:0] alu, input logic [15:0] sd, input logic [15:0] pci,
    input logic ptm, input logic rdy, input logic [15:0] rdata,
    input logic [4:0] e_flags, input logic [15:0] e_maddr,
    input logic [15:0] e_mwdata, input logic [3:0] e_waddr,
    input logic [15:0] e_wdata, input logic [15:0] e_rt);
    vec_t v;
    v.ev = ev; v.m = m; v.wb = wb; v.alu = alu; v.sd = sd; v.pci = pci;
    v.ptm = ptm; v.rdy = rdy; v.rdata = rdata;
    v.e_flags = e_flags; v.e_maddr = e_maddr; v.e_mwdata = e_mwdata;
    v.e_waddr = e_waddr; v.e_wdata = e_wdata; v.e_rt = e_rt;
    return v;
  endfunction

  task automatic drive(input logic ev, input logic [1:0] m, input logic [6:0] wb,
                       input logic [15:0] alu, input logic [15:0] sd,
                       input logic [15:0] pci, input logic ptm,
                       input logic rdy, input logic [15:0] rdata);
    ex_valid = ev; M = m; WB = wb; alu_result = alu; store_data = sd;
    pc_inc = pci; pc_to_mem = ptm; mem_ready = rdy; mem_rdata = rdata;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end else begin
      $display("[TB] ok %s = %h", nm, act);
    end
  endtask

  logic [84:0] act_row;
  logic [84:0] exp_row;

  initial begin
    // WB = {dst[3:0], RegWrite, Ret, MemToReg}
    //             ev  M     WB     alu       sd        pci       ptm  rdy  rdata      flags     maddr     mwdata    wa    wdata     rt
    vecs[0]  = mk(1, 2'b00, 7'h1C, 16'h0012, 16'h0000, 16'h0000, 0, 0, 16'h0000, 5'b00000, 16'h0000, 16'h0000, 4'h0, 16'h0000, 16'h0000); // ADD
    vecs[1]  = mk(0, 2'b00, 7'h00, 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'h0000, 5'b00000, 16'h0000, 16'h0000, 4'h0, 16'h0000, 16'h0000);
    vecs[2]  = mk(1, 2'b01, 7'h2D, 16'h0040, 16'h1234, 16'h0000, 0, 0, 16'h0000, 5'b00010, 16'h0000, 16'h0000, 4'h3, 16'h0012, 16'h0000); // LW
    vecs[3]  = mk(0, 2'b00, 7'h00, 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'h0000, 5'b10100, 16'h0040, 16'h1234, 4'h0, 16'h0000, 16'h0000);
    vecs[4]  = mk(0, 2'b00, 7'h00, 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'h0000, 5'b10100, 16'h0040, 16'h1234, 4'h0, 16'h0000, 16'h0000);
    vecs[5]  = mk(0, 2'b00, 7'h00, 16'h0000, 16'h0000, 16'h0000, 0, 1, 16'hBEEF, 5'b10000, 16'h0040, 16'h1234, 4'h0, 16'h0000, 16'h0000);
    vecs[6]  = mk(1, 2'b10, 7'h7C, 16'h7FFE, 16'h5555, 16'h0101, 1, 0, 16'h0000, 5'b00010, 16'h0000, 16'h0000, 4'h5, 16'hBEEF, 16'h0000); // CALL
    vecs[7]  = mk(0, 2'b00, 7'h00, 16'h0000, 16'h0000, 16'h0000, 0, 1, 16'hDEAD, 5'b11000, 16'h7FFE, 16'h0101, 4'h0, 16'h0000, 16'h0000);
    vecs[8]  = mk(1, 2'b01, 7'h7E, 16'h7FFF, 16'h0000, 16'h0000, 0, 0, 16'h0000, 5'b00010, 16'h0000, 16'h0000, 4'hF, 16'h7FFE, 16'h0000); // RET
    vecs[9]  = mk(0, 2'b00, 7'h00, 16'h0000, 16'h0000, 16'h0000, 0, 1, 16'h0101, 5'b10000, 16'h7FFF, 16'h0000, 4'h0, 16'h0000, 16'h0000);
    vecs[10] = mk(0, 2'b00, 7'h00, 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'h0000, 5'b00011, 16'h0000, 16'h0000, 4'hF, 16'h7FFF, 16'h0101);
    vecs[11] = mk(0, 2'b00, 7'h00, 16'h0000, 16'h0000, 16'h0000, 0, 1, 16'hAAAA, 5'b00000, 16'h0000, 16'h0000, 4'h0, 16'h0000, 16'h0000); // ready in IDLE
    vecs[12] = mk(1, 2'b00, 7'h04, 16'h0077, 16'h0000, 16'h0000, 0, 0, 16'h0000, 5'b00000, 16'h0000, 16'h0000, 4'h0, 16'h0000, 16'h0000); // dst=0
    vecs[13] = mk(1, 2'b11, 7'h35, 16'h0200, 16'hCAFE, 16'h0000, 0, 0, 16'h0000, 5'b00000, 16'h0000, 16'h0000, 4'h0, 16'h0000, 16'h0000); // M=11
    vecs[14] = mk(0, 2'b00, 7'h00, 16'h0000, 16'h0000, 16'h0000, 0, 1, 16'h1111, 5'b11010, 16'h0200, 16'hCAFE, 4'h0, 16'h0077, 16'h0000);
    vecs[15] = mk(1, 2'b00, 7'h38, 16'h9999, 16'h0000, 16'h0000, 0, 0, 16'h0000, 5'b00010, 16'h0000, 16'h0000, 4'h6, 16'h0200, 16'h0000); // RegWrite=0
    vecs[16] = mk(0, 2'b00, 7'h00, 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'h0000, 5'b00000, 16'h0000, 16'h0000, 4'h0, 16'h0000, 16'h0000);
    vecs[17] = mk(0, 2'b00, 7'h00, 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'h0000, 5'b00000, 16'h0000, 16'h0000, 4'h7, 16'h0000, 16'h0000);

    // Reset state.
    drive(0, 2'b00, 7'h00, 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'h0000);
    #12;
    chk("reset_flags", 32'({mem_req, mem_we, stall, reg_write, ret_valid, mem_err}), 32'h0);
    chk("reset_data", 32'(write_data | ret_target | mem_addr | mem_wdata | 16'(write_addr)), 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].ev, vecs[i].m, vecs[i].wb, vecs[i].alu, vecs[i].sd,
            vecs[i].pci, vecs[i].ptm, vecs[i].rdy, vecs[i].rdata);
      #1;
      act_row = {mem_req, mem_we, stall, reg_write, ret_valid,
                 mem_addr, mem_wdata, write_addr, write_data, ret_target};
      exp_row = {vecs[i].e_flags, vecs[i].e_maddr, vecs[i].e_mwdata,
                 vecs[i].e_waddr, vecs[i].e_wdata, vecs[i].e_rt};
      n_run++;
      if (act_row !== exp_row) begin
        n_fail++;
        $display("FAIL row%0d: got %h, expected %h", i, act_row, exp_row);
      end else begin
        $display("[TB] ok row%0d = %h", i, act_row);
      end
      @(posedge clk); #1;
    end

    // Back-to-back SW then LW with immediate ready, then reset mid-access.
    drive(1, 2'b10, 7'h00, 16'h0300, 16'hABCD, 16'h0000, 0, 0, 16'h0000);
    @(posedge clk); #1;
    chk("sw_access", {mem_req, mem_we, mem_addr, 14'h0}, {1'b1, 1'b1, 16'h0300, 14'h0});
    drive(1, 2'b01, 7'h45, 16'h0310, 16'h0000, 16'h0000, 0, 1, 16'h0000);
    #1;
    chk("sw_ready_nostall", 32'(stall), 32'h0);
    @(posedge clk); #1;
    chk("lw_no_gap", {mem_req, mem_we, mem_addr, 14'h0}, {1'b1, 1'b0, 16'h0310, 14'h0});
    drive(0, 2'b00, 7'h00, 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'h0000);
    #1;
    chk("lw_stall", 32'(stall), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset", 32'({mem_req, stall, mem_we, reg_write}), 32'h0);
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("discarded_req", 32'({mem_req, reg_write}), 32'h0);
    @(posedge clk); #1;
    chk("discarded_wb", 32'({mem_req, reg_write, stall}), 32'h0);

`ifdef MEM_TIMEOUT_EN
    begin
      int n_req;
      int guard;
      drive(1, 2'b01, 7'h45, 16'h0500, 16'h0000, 16'h0000, 0, 0, 16'h0000);
      @(posedge clk); #1;
      drive(0, 2'b00, 7'h00, 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'h0000);
      n_req = 0;
      guard = 0;
      while (mem_req && guard < 20) begin
        n_req++;
        guard++;
        @(posedge clk); #1;
      end
      chk("timeout_req_cycles", 32'(n_req), 32'd4);
      chk("timeout_err", 32'({mem_err, reg_write, stall}), 32'b100);
      @(posedge clk); #1;
      chk("timeout_sticky", 32'({mem_err, reg_write}), 32'b10);
    end
`else
    chk("mem_err_tied", 32'(mem_err), 32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_wb_slice.md
Name: mem_wb_slice

Overview:
- Back half of the 5-stage pipeline: consumes the M and WB control bundles produced by the decode stage, plus the EX results.
- Performs the data-memory access through a req/ready handshake and holds the MEM/WB pipeline register.
- Drives the register-file write port back into decode: write_addr, write_data, RegWrite_in.
- Raises stall while a memory access is outstanding and issues the RET redirect target.

Parameters:
- TIMEOUT, 255: maximum cycles to wait for mem_ready before aborting. Used only with MEM_TIMEOUT_EN.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ex_valid  in  1  EX stage presents a valid instruction this cycle.
- alu_result  in  16  ALU output: memory address or register result.
- store_data  in  16  rt/rd read data to store.
- pc_inc  in  16  PC+1 of the instruction; pushed on CALL.
- pc_to_mem  in  1  select pc_inc as store data (CALL).
- M  in  2  {MemWrite, MemRead}.
- WB  in  7  {dst_addr[3:0], RegWrite, Ret, MemToReg}.
- mem_req  out  1  memory request.
- mem_we  out  1  1 = write, 0 = read.
- mem_addr  out  16  memory address.
- mem_wdata  out  16  memory write data.
- mem_rdata  in  16  memory read data, valid when mem_ready=1.
- mem_ready  in  1  memory completes the request this cycle.
- stall  out  1  upstream must freeze and hold its inputs.
- write_addr  out  4  register-file write address.
- write_data  out  16  register-file write data.
- reg_write  out  1  register-file write enable; connects to decode RegWrite_in.
- ret_valid  out  1  one-cycle pulse: RET target available.
- ret_target  out  16  popped return address.
- mem_err  out  1  sticky timeout flag (feature only; tied 0 otherwise).

Behaviour:
Stages:
- MEM register (op captured from the EX inputs), then WB register (drives write_*/ret_*).
- All outputs reset to 0; FSM resets to IDLE.
- Inputs are captured into the MEM register on a rising edge when stall=0. When ex_valid=0 a bubble is captured: all controls are 0.

FSM states IDLE and ACCESS:
- IDLE: if the MEM register holds an op with MemRead|MemWrite, go to ACCESS in the same cycle the register loads. Non-memory ops move to the WB register on the next edge.
- ACCESS: mem_req=1. mem_we=MemWrite, mem_addr=alu_result, mem_wdata = pc_to_mem ? pc_inc : store_data. All are driven from registers and stay stable while waiting.
- stall = (state==ACCESS) & ~mem_ready.
- When mem_ready=1 in ACCESS: capture mem_rdata, load the WB register, accept the next EX op, return to IDLE. A new memory op captured on that same edge goes straight back to ACCESS with no idle cycle.

Latency:
- Non-memory op: write outputs valid 2 edges after capture from EX.
- Memory op: write outputs valid on the edge after mem_ready is sampled high.

WB register contents:
- reg_write = RegWrite.
- write_addr = dst_addr.
- write_data = MemToReg ? rdata : alu_result. write_data is 0 when RegWrite=0.
- ret_valid = Ret, pulsed for one cycle.
- ret_target = rdata. A RET op writes alu_result (the new SP) to r15 and returns rdata as the target.

Boundary cases:
- Bubbles produce reg_write=0 and ret_valid=0.
- dst_addr=0 is written unfiltered; the register file ignores it.
- mem_ready asserted while in IDLE is ignored.
- Both MemRead and MemWrite set: treated as a write; no register data from memory.
- rst_n low mid-access: mem_req, stall and all outputs drop to 0 immediately (asynchronously); the op is discarded.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- With the macro defined:
  - A counter clears on entry to ACCESS and increments each cycle.
  - When it reaches TIMEOUT without mem_ready, return to IDLE, load the WB register with reg_write=0 and ret_valid=0, and set mem_err.
  - mem_err stays set until reset.
- Without the macro: no counter; the block waits indefinitely and mem_err is constant 0.

Test Plan:
- ADD: alu_result=16'h0012, WB={4'h3,1,0,0}, M=0 -> two edges later reg_write=1, write_addr=3, write_data=16'h0012; stall never asserts.
- LW: M=2'b01, alu_result=16'h0040, WB={4'h5,1,0,1}, mem_ready after 3 cycles with mem_rdata=16'hBEEF -> mem_req high 3 cycles, stall high 2 cycles, then write_addr=5 and write_data=16'hBEEF.
- CALL: M=2'b10, pc_to_mem=1, pc_inc=16'h0101, alu_result=16'h7FFE, WB={4'hF,1,0,0} -> mem_we=1, mem_addr=16'h7FFE, mem_wdata=16'h0101; then r15 is written with 16'h7FFE.
- RET: M=2'b01, alu_result=16'h7FFF, WB={4'hF,1,1,0}, mem_rdata=16'h0101 -> ret_valid pulses one cycle with ret_target=16'h0101; write_data=16'h7FFF.
- Back-to-back SW then LW with mem_ready=1 immediately -> second access starts on the next cycle with no IDLE gap; rst_n low during the second access -> mem_req and stall go to 0 without waiting for a clock edge.
- MEM_TIMEOUT_EN with TIMEOUT=4 and mem_ready held low -> abort after 4 cycles, mem_err=1, reg_write stays 0.
